// File: rtl/univ_shift_reg_pkg.sv
// ============================================================================
// univ_shift_pkg : command and state encodings for the universal shift register
// Rev 1.0
// ============================================================================
`default_nettype none

package univ_shift_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD  = 3'b000,
    MODE_SHR   = 3'b001,
    MODE_SHL   = 3'b010,
    MODE_LOAD  = 3'b011,
    MODE_ROTR  = 3'b100,
    MODE_ROTL  = 3'b101,
    MODE_CLEAR = 3'b110,
    MODE_BURST = 3'b111
  } mode_e;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

endpackage : univ_shift_pkg

`default_nettype wire

// File: rtl/univ_shift_reg.sv
// ============================================================================
// univ_shift_reg : shift/rotate/load register with a counted burst right-shift
// Rev 1.0
// ============================================================================
`default_nettype none

module univ_shift_reg
  import univ_shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] parallel_in,
  input  logic             serial_in_r,
  input  logic             serial_in_l,
  input  logic [CNT_W-1:0] shamt,
  output logic [WIDTH-1:0] parallel_out,
  output logic             serial_out_r,
  output logic             serial_out_l,
  output logic             busy,
  output logic             done
);

  // Counter only ever holds the clamped count, so it is sized to WIDTH.
  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] data_q, data_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  state_e           state_q, state_d;
  logic             done_q, done_d;
  logic [CW-1:0]    shamt_clamped;

  always_comb begin
    if (32'(shamt) > 32'(WIDTH)) shamt_clamped = CW'(WIDTH);
    else                         shamt_clamped = CW'(shamt);
  end

  always_comb begin
    data_d  = data_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (en) begin
          unique case (mode_e'(mode))
            MODE_HOLD:  data_d = data_q;
            MODE_SHR:   data_d = {serial_in_r, data_q[WIDTH-1:1]};
            MODE_SHL:   data_d = {data_q[WIDTH-2:0], serial_in_l};
            MODE_LOAD:  data_d = parallel_in;
            MODE_ROTR:  data_d = {data_q[0], data_q[WIDTH-1:1]};
            MODE_ROTL:  data_d = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
            MODE_CLEAR: data_d = '0;
            MODE_BURST: begin
              // A zero-length burst completes immediately without entering BURST.
              if (shamt_clamped != '0) begin
                cnt_d   = shamt_clamped;
                state_d = ST_BURST;
              end else begin
                done_d  = 1'b1;
              end
            end
            default: data_d = data_q;
          endcase
        end
      end
      ST_BURST: begin
        data_d = {serial_in_r, data_q[WIDTH-1:1]};
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      cnt_q   <= '0;
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
    end else begin
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  assign parallel_out = data_q;
  assign serial_out_r = data_q[0];
  assign serial_out_l = data_q[WIDTH-1];
  assign busy         = (state_q == ST_BURST);
  assign done         = done_q;

endmodule : univ_shift_reg

`default_nettype wire

// File: tb/tb_univ_shift_reg.sv
// ============================================================================
// tb_univ_shift_reg : directed vectors checked against a behavioural model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_univ_shift_reg;

  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);

  logic          clk;
  logic          rst;
  logic          en;
  logic [2:0]    mode;
  logic [W-1:0]  parallel_in;
  logic          serial_in_r;
  logic          serial_in_l;
  logic [CW-1:0] shamt;
  logic [W-1:0]  parallel_out;
  logic          serial_out_r;
  logic          serial_out_l;
  logic          busy;
  logic          done;

  int checks   = 0;
  int failures = 0;

  univ_shift_reg #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .mode        (mode),
    .parallel_in (parallel_in),
    .serial_in_r (serial_in_r),
    .serial_in_l (serial_in_l),
    .shamt       (shamt),
    .parallel_out(parallel_out),
    .serial_out_r(serial_out_r),
    .serial_out_l(serial_out_l),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: register as an integer value, burst as a count of shifts still owed.
  longint unsigned m_val;
  int              m_rem;
  bit              m_done;
  localparam longint unsigned MASK = (64'd1 << W) - 1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_val  = 0;
      m_rem  = 0;
      m_done = 0;
    end else begin
      m_done = 0;
      if (m_rem > 0) begin
        m_val = (m_val >> 1) | (longint'(serial_in_r) << (W - 1));
        m_rem = m_rem - 1;
        if (m_rem == 0) m_done = 1;
      end else if (en) begin
        case (mode)
          3'd1: m_val = (m_val >> 1) | (longint'(serial_in_r) << (W - 1));
          3'd2: m_val = ((m_val << 1) | longint'(serial_in_l)) & MASK;
          3'd3: m_val = longint'(parallel_in);
          3'd4: m_val = (m_val >> 1) | ((m_val & 1) << (W - 1));
          3'd5: m_val = ((m_val << 1) & MASK) | (m_val >> (W - 1));
          3'd6: m_val = 0;
          3'd7: begin
            m_rem = (int'(shamt) > W) ? W : int'(shamt);
            if (m_rem == 0) m_done = 1;
          end
          default: ;
        endcase
      end
    end
  end

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("cyc_parallel_out", longint'(parallel_out), m_val);
    chk("cyc_serial_out_r", longint'(serial_out_r), m_val & 1);
    chk("cyc_serial_out_l", longint'(serial_out_l), (m_val >> (W - 1)) & 1);
    chk("cyc_busy", longint'(busy), longint'(m_rem > 0));
    chk("cyc_done", longint'(done), longint'(m_done));
  end

  task automatic drive(input bit e, input logic [2:0] m, input logic [W-1:0] p,
                       input bit sr, input bit sl, input logic [CW-1:0] sh);
    en = e; mode = m; parallel_in = p; serial_in_r = sr; serial_in_l = sl; shamt = sh;
    @(posedge clk);
    #2;
  endtask

  logic [W-1:0] pattern;

  initial begin
    rst = 1'b0; en = 1'b0; mode = '0; parallel_in = '0;
    serial_in_r = 1'b0; serial_in_l = 1'b0; shamt = '0;
    #1 rst = 1'b1;
    #1;
    chk("reset_value", longint'(parallel_out), 0);
    chk("reset_busy", longint'(busy), 0);
    chk("reset_done", longint'(done), 0);
    @(posedge clk);
    #2 rst = 1'b0;

    // Load, shift, clear
    drive(1, 3'd3, 8'hA5, 0, 0, 0); chk("load_A5", longint'(parallel_out), 64'hA5);
    chk("model_load_A5", m_val, 64'hA5);
    drive(1, 3'd1, 8'h00, 1, 0, 0); chk("shr_D2", longint'(parallel_out), 64'hD2);
    drive(1, 3'd2, 8'h00, 0, 0, 0); chk("shl_A4", longint'(parallel_out), 64'hA4);
    chk("model_shl_A4", m_val, 64'hA4);
    drive(1, 3'd6, 8'h00, 0, 0, 0); chk("clear_00", longint'(parallel_out), 64'h00);

    // Rotate and hold
    drive(1, 3'd3, 8'h81, 0, 0, 0); chk("load_81", longint'(parallel_out), 64'h81);
    drive(1, 3'd4, 8'h00, 0, 0, 0); chk("rotr_C0", longint'(parallel_out), 64'hC0);
    drive(1, 3'd5, 8'h00, 0, 0, 0); chk("rotl_81", longint'(parallel_out), 64'h81);
    drive(1, 3'd5, 8'h00, 0, 0, 0); chk("rotl_03", longint'(parallel_out), 64'h03);
    chk("model_rotl_03", m_val, 64'h03);
    drive(0, 3'd1, 8'h00, 1, 1, 0); chk("en0_hold_03", longint'(parallel_out), 64'h03);

    // Burst of 3 with mode churn while busy
    drive(1, 3'd3, 8'hFF, 0, 0, 0);
    drive(1, 3'd7, 8'h00, 0, 0, 3);  chk("b3_accept_busy", longint'(busy), 1);
    chk("b3_accept_noshift", longint'(parallel_out), 64'hFF);
    drive(1, 3'd3, 8'h00, 0, 0, 0);  chk("b3_s1_busy", longint'(busy), 1);
    chk("b3_s1_val", longint'(parallel_out), 64'h7F);
    drive(1, 3'd6, 8'h00, 0, 0, 0);  chk("b3_s2_busy", longint'(busy), 1);
    drive(1, 3'd2, 8'h00, 0, 1, 0);  chk("b3_s3_busy", longint'(busy), 0);
    chk("b3_final_1F", longint'(parallel_out), 64'h1F);
    chk("b3_done", longint'(done), 1);
    chk("model_b3_1F", m_val, 64'h1F);
    drive(0, 3'd0, 8'h00, 0, 0, 0);  chk("b3_done_cleared", longint'(done), 0);

    // Zero-length burst
    drive(1, 3'd7, 8'h00, 1, 0, 0);  chk("b0_value", longint'(parallel_out), 64'h1F);
    chk("b0_busy", longint'(busy), 0);
    chk("b0_done", longint'(done), 1);
    drive(0, 3'd0, 8'h00, 0, 0, 0);  chk("b0_done_cleared", longint'(done), 0);

    // Clamped burst: 15 -> 8 shifts, register equals the applied bits
    pattern = 8'h6B;
    drive(1, 3'd7, 8'h00, 0, 0, 15); chk("b15_accept_busy", longint'(busy), 1);
    for (int i = 0; i < W; i++) begin
      drive(1, 3'd3, 8'h55, pattern[i], 0, 0);
      chk($sformatf("b15_busy_%0d", i), longint'(busy), (i < W - 1) ? 1 : 0);
    end
    chk("b15_final", longint'(parallel_out), 64'h6B);
    chk("b15_done", longint'(done), 1);
    drive(0, 3'd0, 8'h00, 0, 0, 0);  chk("b15_done_cleared", longint'(done), 0);

    // Reset in the middle of an 8-shift burst
    drive(1, 3'd3, 8'hFF, 0, 0, 0);
    drive(1, 3'd7, 8'h00, 0, 0, 8);
    for (int i = 0; i < 3; i++) drive(1, 3'd0, 8'h00, 0, 0, 0);
    chk("rb_mid_val", longint'(parallel_out), 64'h1F);
    chk("rb_mid_busy", longint'(busy), 1);
    #1 rst = 1'b1;
    #1;
    chk("rb_async_val", longint'(parallel_out), 0);
    chk("rb_async_busy", longint'(busy), 0);
    chk("rb_async_done", longint'(done), 0);
    @(posedge clk);
    #2 rst = 1'b0;
    drive(0, 3'd0, 8'h00, 0, 0, 0);  chk("rb_no_done", longint'(done), 0);
    chk("rb_idle_busy", longint'(busy), 0);
    drive(1, 3'd3, 8'h3C, 0, 0, 0);  chk("rb_load_3C", longint'(parallel_out), 64'h3C);
    drive(0, 3'd0, 8'h00, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_univ_shift_reg

`default_nettype wire

// File: doc/univ_shift_reg.md
UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 Parameter: WIDTH, default 8, register width in bits (legal range 2..64).
REQ-002 Parameter: CNT_W, default $clog2(WIDTH+1), width of the burst shift-count port.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-high reset.
REQ-005 Port: en  input  1  mode-command qualifier; when low, IDLE holds the register.
REQ-006 Port: mode  input  3  command select, encoding per REQ-011.
REQ-007 Port: parallel_in  input  WIDTH  load data.
REQ-008 Port: serial_in_r / serial_in_l  input  1 each  fill bits for right / left shifts.
REQ-009 Port: shamt  input  CNT_W  burst shift count, sampled on burst start.
REQ-010 Port: parallel_out  output  WIDTH  register contents; serial_out_r / serial_out_l  output  1 each  = parallel_out[0] / parallel_out[WIDTH-1]; busy  output  1; done  output  1.

Function
REQ-011 Mode encoding: 000 hold; 001 shift right (serial_in_r into MSB); 010 shift left (serial_in_l into LSB); 011 parallel load; 100 rotate right; 101 rotate left; 110 synchronous clear to 0; 111 burst shift right.
REQ-012 Single-step modes 000-110: applied on the clock edge where en=1 and state is IDLE; one-cycle latency to parallel_out.
REQ-013 State machine: two states, IDLE and BURST.
REQ-014 IDLE->BURST: en=1, mode=111, shamt clamped to WIDTH is nonzero; the counter loads the clamped shamt; no shift on this edge.
REQ-015 In BURST: each cycle shifts right once with the current serial_in_r into the MSB and decrements the counter; en, mode, parallel_in and shamt are ignored.
REQ-016 BURST->IDLE: on the edge where the counter goes 1->0; that same edge performs the final shift.
REQ-017 A burst of N (N>=1) occupies exactly N cycles in BURST.
REQ-018 shamt values greater than WIDTH SHALL be clamped to WIDTH, giving a full register replacement.
REQ-019 Burst with shamt=0: no state change and no shift; done pulses for one cycle on the next edge.
REQ-020 busy SHALL be 1 exactly while the state is BURST (registered).
REQ-021 done SHALL pulse high for one cycle, in the cycle after the final burst shift (coincident with the return to IDLE); otherwise 0.
REQ-022 A new command is accepted on the first IDLE edge after done, so back-to-back bursts leave no dead cycle beyond the IDLE accept edge.
REQ-023 The serial outputs SHALL be combinational taps of the register, so they carry no extra latency.

Reset
REQ-024 rst=1 SHALL immediately, without waiting for clk, force parallel_out=0, counter=0, state=IDLE, busy=0 and done=0.
REQ-025 Reset asserted mid-burst SHALL abort the burst with no done pulse; after release the block accepts commands on the first rising edge.

Structure
REQ-026 Package univ_shift_pkg SHALL hold the mode enum (3-bit) and the state enum (IDLE, BURST).
REQ-027 The block SHALL be a single module with no sub-module: one register, one down-counter and a two-state FSM.

Verification (WIDTH=8)
REQ-028 Load, shift and clear: load 0xA5 -> 0xA5; shift right, serial_in_r=1 -> 0xD2; shift left, serial_in_l=0 -> 0xA4; clear -> 0x00.
REQ-029 Rotate and hold: load 0x81; rotate right -> 0xC0; rotate left twice -> 0x03; en=0 with mode=001 -> stays 0x03.
REQ-030 Burst of 3: load 0xFF; burst shamt=3, serial_in_r=0 -> busy high 3 cycles, final value 0x1F, done one cycle, mode changes during busy have no effect.
REQ-031 Burst edge cases: shamt=0 -> value unchanged, busy never high, done one cycle; shamt=15 -> clamped to 8, busy 8 cycles, register equals the 8 serial bits applied.
REQ-032 Reset mid-burst: burst shamt=8 from 0xFF; assert rst in cycle 4 -> immediate 0x00, busy=0, no done pulse; after release, load 0x3C -> 0x3C.
